matmul_mem_arbiter: RTL and testbench

MATMUL_MEM_ARBITER -- requirements
Module: matmul_mem_arbiter

---
 rtl/matmul_mem_pkg.sv | 19 +
 rtl/matmul_mem_slot.sv | 52 +++++
 rtl/matmul_mem_arbiter.sv | 101 ++++++++++
 tb/tb_matmul_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_mem_pkg.sv
// Shared types and defaults for the matmul operand-load arbiter and its per-requester slots.
// The 16-bit stall counter saturation helper lives here so the top keeps only wiring and arbitration.
package matmul_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    HOLD     = 2'd2
  } slot_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt, input logic inc);
    return (inc && (cnt != STALL_MAX)) ? cnt + 16'd1 : cnt;
  endfunction

endpackage

// File: rtl/matmul_mem_slot.sv
// One requester's load tracker: IDLE -> INFLIGHT on grant, capture memory return, HOLD until taken.
// Data valid two cycles after the grant; held stable while data_ready is low.
module matmul_mem_slot
  import matmul_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              grant,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              data_ready,
  output logic              idle,
  output logic [DATA_W-1:0] data,
  output logic              data_valid
);

  slot_state_t state;

  assign idle = (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) state <= INFLIGHT;
        end
        INFLIGHT: begin
          data       <= mem_rdata;
          data_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          // data_ready outside HOLD never reaches here, so it is ignored there
          if (data_ready) begin
            data_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          data_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/matmul_mem_arbiter.sv
// Round-robin arbiter feeding two operand load streams from one single-port memory (A at 0..15, B at 16..31).
// Grant and mem_en are combinational with the address handshake; data valid two cycles later, held under backpressure.
module matmul_mem_arbiter
  import matmul_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_addr_valid,
  output logic              req0_addr_ready,
  output logic [DATA_W-1:0] req0_data,
  output logic              req0_data_valid,
  input  logic              req0_data_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_addr_valid,
  output logic              req1_addr_ready,
  output logic [DATA_W-1:0] req1_data,
  output logic              req1_data_valid,
  input  logic              req1_data_ready,
  output logic              mem_en,
  output logic [ADDR_W:0]   mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_count
);

  logic            idle0;
  logic            idle1;
  logic            cand0;
  logic            cand1;
  logic            contend;
  logic            grant0;
  logic            grant1;
  logic            last_grant;
  logic [ADDR_W:0] addr_hold;
  logic [15:0]     stall_cnt;

  assign cand0   = req0_addr_valid & idle0;
  assign cand1   = req1_addr_valid & idle1;
  assign contend = cand0 & cand1;

  // An idle requester is only held off when the other one is contending and owns priority.
  assign req0_addr_ready = ~reset & idle0 & ~(cand1 & ~last_grant);
  assign req1_addr_ready = ~reset & idle1 & ~(cand0 & last_grant);

  assign grant0 = req0_addr_valid & req0_addr_ready;
  assign grant1 = req1_addr_valid & req1_addr_ready;
  assign mem_en = grant0 | grant1;

  always_comb begin
    mem_addr = addr_hold;
    if (reset) begin
      mem_addr = '0;
    end else if (grant0) begin
      mem_addr = {1'b0, req0_addr};
    end else if (grant1) begin
      mem_addr = {1'b1, req1_addr};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
      addr_hold  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (mem_en) begin
        last_grant <= grant1;
        addr_hold  <= mem_addr;
      end
      stall_cnt <= sat_inc16(stall_cnt, contend);
    end
  end

  assign stall_count = stall_cnt;

  matmul_mem_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clock      (clock),
    .reset      (reset),
    .grant      (grant0),
    .mem_rdata  (mem_rdata),
    .data_ready (req0_data_ready),
    .idle       (idle0),
    .data       (req0_data),
    .data_valid (req0_data_valid)
  );

  matmul_mem_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clock      (clock),
    .reset      (reset),
    .grant      (grant1),
    .mem_rdata  (mem_rdata),
    .data_ready (req1_data_ready),
    .idle       (idle1),
    .data       (req1_data),
    .data_valid (req1_data_valid)
  );

endmodule

// File: tb/tb_matmul_mem_arbiter.sv
// Directed bench for matmul_mem_arbiter with a 32-word memory model (A[i]=i+1, B[i]=16-i).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_matmul_mem_arbiter;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0][3:0] addr_in = '0;
  logic [1:0]      valid_in = '0;
  logic [1:0]      ready_in = '0;
  logic [1:0]      addr_ready;
  logic [1:0]      data_valid;
  logic [1:0][31:0] rdata;
  logic            mem_en;
  logic [4:0]      mem_addr;
  logic [31:0]     mem_rdata;
  logic [15:0]     stall_count;

  int   n_chk = 0;
  int   n_pass = 0;
  int   mon_err = 0;
  logic mon_on = 1'b0;
  logic [4:0] prev_addr = '0;

  always #5 clock = ~clock;

  matmul_mem_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .req0_addr       (addr_in[0]),
    .req0_addr_valid (valid_in[0]),
    .req0_addr_ready (addr_ready[0]),
    .req0_data       (rdata[0]),
    .req0_data_valid (data_valid[0]),
    .req0_data_ready (ready_in[0]),
    .req1_addr       (addr_in[1]),
    .req1_addr_valid (valid_in[1]),
    .req1_addr_ready (addr_ready[1]),
    .req1_data       (rdata[1]),
    .req1_data_valid (data_valid[1]),
    .req1_data_ready (ready_in[1]),
    .mem_en          (mem_en),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .stall_count     (stall_count)
  );

  function automatic logic [31:0] mem_word(input logic [4:0] a);
    return a[4] ? 32'd16 - 32'(a[3:0]) : 32'(a[3:0]) + 32'd1;
  endfunction

  always @(posedge clock) mem_rdata <= mem_en ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Arbitration monitor: one grant per cycle, strobe/address follow the handshake, address held otherwise.
  always @(negedge clock) begin
    logic h0, h1;
    #2;
    h0 = valid_in[0] & addr_ready[0];
    h1 = valid_in[1] & addr_ready[1];
    if (mon_on) begin
      if (h0 && h1) mon_err++;
      if (mem_en !== (h0 | h1)) mon_err++;
      if (h0 && mem_addr !== {1'b0, addr_in[0]}) mon_err++;
      if (h1 && !h0 && mem_addr !== {1'b1, addr_in[1]}) mon_err++;
      if (!mem_en && mem_addr !== prev_addr) mon_err++;
    end
    prev_addr = mem_addr;
  end

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    valid_in = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Call just after a falling edge. Returns data, cycles from accept to data valid, and backpressure errors.
  task automatic load(input int n, input logic [3:0] a, input int stall,
                      output logic [31:0] d, output int lat, output int bp_err);
    int t;
    d = '0; lat = 0; bp_err = 0; t = 0;
    addr_in[n]  = a;
    valid_in[n] = 1'b1;
    ready_in[n] = (stall == 0);
    #1;
    while (!addr_ready[n]) begin
      @(negedge clock); #1;
      t++;
      if (t > 64) begin
        check("addr_timeout", 32'(t), 0);
        valid_in[n] = 1'b0;
        return;
      end
    end
    @(negedge clock);
    valid_in[n] = 1'b0;
    lat = 1;
    #1;
    while (!data_valid[n]) begin
      @(negedge clock); #1;
      lat++;
      if (lat > 64) begin
        check("data_timeout", 32'(lat), 2);
        return;
      end
    end
    d = rdata[n];
    for (int k = 0; k < stall; k++) begin
      @(negedge clock); #1;
      if (rdata[n] !== d || !data_valid[n] || addr_ready[n] ||
          (mem_en && mem_addr[4] == n[0])) bp_err++;
    end
    ready_in[n] = 1'b1;
    @(negedge clock); #1;
    if (data_valid[n]) bp_err++;
  endtask

  initial begin
    logic [31:0] d, d2;
    int lat, lat2, e, e2, dv_seen, dot, eab;
    logic [31:0] sa [16];
    logic [31:0] sb [16];
    int la [16];
    int lb [16];
    int ea [16];
    int eb [16];

    // reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_data_valid", 32'(data_valid), 0);
    check("rst_stall", 32'(stall_count), 0);
    check("rst_data0", rdata[0], 0);
    check("rst_data1", rdata[1], 0);
    reset = 1'b0;
    #1;
    check("rst_addr_ready", 32'(addr_ready), 32'b11);

    // single load of A[3]
    @(negedge clock);
    addr_in[0] = 4'd3; valid_in[0] = 1'b1; ready_in[0] = 1'b1;
    #1;
    check("single_mem_en", 32'(mem_en), 1);
    check("single_mem_addr", 32'(mem_addr), 3);
    @(negedge clock);
    valid_in[0] = 1'b0;
    #1;
    check("single_dv_t1", 32'(data_valid[0]), 0);
    @(negedge clock); #1;
    check("single_dv_t2", 32'(data_valid[0]), 1);
    check("single_data", rdata[0], 4);
    check("single_stall", 32'(stall_count), 0);
    @(negedge clock); #1;
    check("single_dv_done", 32'(data_valid[0]), 0);

    // contention right after reset: req0 first, req1 next cycle
    do_reset();
    addr_in = '0; valid_in = 2'b11; ready_in = 2'b11;
    #1;
    check("cont_ready_t0", 32'(addr_ready), 32'b01);
    check("cont_addr_t0", 32'(mem_addr), 0);
    check("cont_en_t0", 32'(mem_en), 1);
    @(negedge clock);
    valid_in[0] = 1'b0;
    #1;
    check("cont_ready_t1", 32'(addr_ready[1]), 1);
    check("cont_addr_t1", 32'(mem_addr), 16);
    @(negedge clock);
    valid_in[1] = 1'b0;
    #1;
    check("cont_dv0", 32'(data_valid[0]), 1);
    check("cont_data0", rdata[0], 1);
    @(negedge clock); #1;
    check("cont_dv1", 32'(data_valid[1]), 1);
    check("cont_data1", rdata[1], 16);
    check("cont_stall", 32'(stall_count), 1);
    @(negedge clock); #1;

    // backpressure on req1 for 5 cycles
    load(1, 4'd5, 5, d, lat, e);
    check("bp_data", d, 11);
    check("bp_latency", 32'(lat), 2);
    check("bp_stable", 32'(e), 0);

    // streaming dot product of A and B
    mon_on = 1'b1;
    fork
      for (int i = 0; i < 16; i++) load(0, 4'(i), 0, sa[i], la[i], ea[i]);
      for (int i = 0; i < 16; i++) load(1, 4'(i), 0, sb[i], lb[i], eb[i]);
    join
    mon_on = 1'b0;
    dot = 0; eab = 0;
    for (int i = 0; i < 16; i++) begin
      check("stream_a", sa[i], 32'(i + 1));
      check("stream_b", sb[i], 32'(16 - i));
      dot += int'(sa[i]) * int'(sb[i]);
      if (la[i] != 2 || lb[i] != 2 || ea[i] != 0 || eb[i] != 0) eab++;
    end
    check("stream_lat_hs", 32'(eab), 0);
    check("stream_dot", 32'(dot), 816);
    check("stream_monitor", 32'(mon_err), 0);

    // reset in the cycle after req0's grant
    @(negedge clock);
    addr_in[0] = 4'd7; valid_in[0] = 1'b1; ready_in = 2'b11;
    #1;
    check("mf_grant", 32'({addr_ready[0], mem_en}), 32'b11);
    @(negedge clock);
    reset = 1'b1; valid_in[0] = 1'b0;
    @(negedge clock); #1;
    check("mf_dv_in_reset", 32'(data_valid[0]), 0);
    reset = 1'b0;
    dv_seen = 0;
    repeat (4) begin
      @(negedge clock); #1;
      if (data_valid[0]) dv_seen++;
    end
    check("mf_never_valid", 32'(dv_seen), 0);
    check("mf_data_clear", rdata[0], 0);
    check("mf_addr_ready", 32'(addr_ready[0]), 1);
    addr_in = {4'd2, 4'd2}; valid_in = 2'b11;
    #1;
    check("mf_next_grant", 32'(addr_ready), 32'b01);
    check("mf_next_addr", 32'(mem_addr), 2);
    @(negedge clock);
    valid_in = 2'b00;
    @(negedge clock); #1;
    check("mf_next_data", rdata[0], 3);
    repeat (2) @(negedge clock);
    #1;

    // saturation of the stall counter
    @(negedge clock);
    force dut.stall_cnt = 16'hFFFD;
    @(negedge clock);
    release dut.stall_cnt;
    #1;
    check("sat_preset", 32'(stall_count), 32'hFFFD);
    for (int k = 0; k < 3; k++) begin
      fork
        load(0, 4'(k), 0, d, lat, e);
        load(1, 4'(k), 0, d2, lat2, e2);
      join
      check("sat_count", 32'(stall_count), (k == 0) ? 32'hFFFE : 32'hFFFF);
      check("sat_data", d + d2, 32'd17);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
